// File: rtl/rfetch_sb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rfetch_sb : register-fetch stage, N-read/M-write regfile, bypass, busy SB  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module rfetch_sb #(
  parameter int XLEN      = 32,
  parameter int NUM_REGS  = 32,
  parameter int RIDX      = $clog2(NUM_REGS),
  parameter int NUM_RD    = 2,
  parameter int NUM_WR    = 1,
  parameter int PAYLOAD_W = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NUM_RD*RIDX-1:0] in_rs,
  input  logic [RIDX-1:0]        in_rd,
  input  logic                   in_rd_we,
  input  logic [PAYLOAD_W-1:0]   in_payload,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NUM_RD*XLEN-1:0] out_rs_data,
  output logic [RIDX-1:0]        out_rd,
  output logic                   out_rd_we,
  output logic [PAYLOAD_W-1:0]   out_payload,
  input  logic [NUM_WR-1:0]      wb_we,
  input  logic [NUM_WR*RIDX-1:0] wb_rd,
  input  logic [NUM_WR*XLEN-1:0] wb_data
);

  logic [XLEN-1:0]        r_regs [NUM_REGS];
  logic [NUM_REGS-1:0]    r_busy;
  logic [NUM_REGS-1:0]    w_busy_nxt;
  logic [NUM_REGS-1:0]    w_wb_hit;
  logic [NUM_RD*XLEN-1:0] w_opnd;
  logic [NUM_RD-1:0]      w_rs_haz;
  logic                   w_rd_haz;
  logic                   w_hazard;
  logic                   w_accept;

  always_comb begin
    w_wb_hit = '0;
    for (int j = 0; j < NUM_WR; j++) begin
      if (wb_we[j] && wb_rd[j*RIDX +: RIDX] != '0)
        w_wb_hit[wb_rd[j*RIDX +: RIDX]] = 1'b1;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [RIDX-1:0] w_rs;
    logic [XLEN-1:0] w_val;

    assign w_rs = in_rs[k*RIDX +: RIDX];

    // Later wb ports override earlier ones, matching regfile write priority.
    always_comb begin
      w_val = r_regs[w_rs];
      for (int j = 0; j < NUM_WR; j++) begin
        if (wb_we[j] && wb_rd[j*RIDX +: RIDX] == w_rs)
          w_val = wb_data[j*XLEN +: XLEN];
      end
      if (w_rs == '0)
        w_val = '0;
    end

    assign w_opnd[k*XLEN +: XLEN] = w_val;
    assign w_rs_haz[k] = (w_rs != '0) && r_busy[w_rs] && !w_wb_hit[w_rs];
  end

  assign w_rd_haz = in_rd_we && (in_rd != '0) && r_busy[in_rd] && !w_wb_hit[in_rd];
  assign w_hazard = (|w_rs_haz) | w_rd_haz;
  assign in_ready = (~out_valid | out_ready) & ~w_hazard & ~flush;
  assign w_accept = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++)
        r_regs[r] <= '0;
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (wb_we[j] && wb_rd[j*RIDX +: RIDX] != '0)
          r_regs[wb_rd[j*RIDX +: RIDX]] <= wb_data[j*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    w_busy_nxt = r_busy & ~w_wb_hit;
    if (flush)
      w_busy_nxt = '0;
    else if (w_accept && in_rd_we && in_rd != '0)
      w_busy_nxt[in_rd] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_busy <= '0;
    else
      r_busy <= w_busy_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_rs_data <= '0;
      out_rd      <= '0;
      out_rd_we   <= 1'b0;
      out_payload <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (w_accept) begin
      out_valid   <= 1'b1;
      out_rs_data <= w_opnd;
      out_rd      <= in_rd;
      out_rd_we   <= in_rd_we;
      out_payload <= in_payload;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rfetch_sb.sv
`default_nettype none
// Directed bench for rfetch_sb (NUM_WR=2): scoreboard queue checked by a negedge monitor.
module tb_rfetch_sb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [9:0]  in_rs;
  logic [4:0]  in_rd;
  logic        in_rd_we;
  logic [63:0] in_payload;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_rs_data;
  logic [4:0]  out_rd;
  logic        out_rd_we;
  logic [63:0] out_payload;
  logic [1:0]  wb_we;
  logic [9:0]  wb_rd;
  logic [63:0] wb_data;

  typedef struct packed {
    logic [63:0] rs;
    logic [4:0]  rd;
    logic        we;
    logic [63:0] pl;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   pl_cnt   = 0;

  rfetch_sb #(.NUM_WR(2)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_rs(in_rs), .in_rd(in_rd),
    .in_rd_we(in_rd_we), .in_payload(in_payload),
    .out_valid(out_valid), .out_ready(out_ready), .out_rs_data(out_rs_data),
    .out_rd(out_rd), .out_rd_we(out_rd_we), .out_payload(out_payload),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got rs_data 0x%0h expected no transfer", out_rs_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("out_rs_data", out_rs_data, mon_e.rs);
        check("out_rd", {59'd0, out_rd}, {59'd0, mon_e.rd});
        check("out_rd_we", {63'd0, out_rd_we}, {63'd0, mon_e.we});
        check("out_payload", out_payload, mon_e.pl);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wb(input logic [1:0] we, input logic [4:0] a0, input logic [31:0] d0,
                        input logic [4:0] a1, input logic [31:0] d1);
    wb_we   = we;
    wb_rd   = {a1, a0};
    wb_data = {d1, d0};
  endtask

  // Present one instruction for one cycle; push its expected output if accepted.
  task automatic issue(input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] rd,
                       input logic we, input logic [31:0] e0, input logic [31:0] e1,
                       input logic rdy);
    exp_t e;
    in_valid   = 1'b1;
    in_rs      = {r1, r0};
    in_rd      = rd;
    in_rd_we   = we;
    in_payload = {32'hA11CE000, pl_cnt};
    pl_cnt++;
    #1;
    check("in_ready", {63'd0, in_ready}, {63'd0, rdy});
    if (in_valid && in_ready) begin
      e.rs = {e1, e0};
      e.rd = rd;
      e.we = we;
      e.pl = in_payload;
      exp_q.push_back(e);
    end
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_rs = '0; in_rd = '0;
    in_rd_we = 1'b0; in_payload = '0; out_ready = 1'b1;
    set_wb(2'b00, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_rs_data", out_rs_data, 64'd0);
    check("rst_out_payload", out_payload, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    rst_n = 1'b1;
    tick();

    // Write x5 then read it back, with x0 on the second port.
    set_wb(2'b01, 5, 32'hDEADBEEF, 0, 0);
    tick();
    set_wb(2'b00, 0, 0, 0, 0);
    issue(5, 0, 0, 0, 32'hDEADBEEF, 32'h0, 1'b1);
    check("latency_out_valid", {63'd0, out_valid}, 64'd1);

    // Same-cycle bypass of x7, then regfile holds it.
    set_wb(2'b01, 7, 32'h1234, 0, 0);
    issue(7, 5, 0, 0, 32'h1234, 32'hDEADBEEF, 1'b1);
    set_wb(2'b00, 0, 0, 0, 0);
    issue(7, 7, 0, 0, 32'h1234, 32'h1234, 1'b1);

    // RAW: rd=3 busy until write-back, which is bypassed into the stalled instruction.
    issue(0, 0, 3, 1'b1, 32'h0, 32'h0, 1'b1);
    in_valid = 1'b1; in_rs = {5'd0, 5'd3}; in_rd = 5'd0; in_rd_we = 1'b0;
    in_payload = 64'hBEEF_0003_0000_0001;
    #1;
    check("raw_stall0", {63'd0, in_ready}, 64'd0);
    tick();
    check("raw_stall1", {63'd0, in_ready}, 64'd0);
    set_wb(2'b01, 3, 32'hA5, 0, 0);
    #1;
    check("raw_release", {63'd0, in_ready}, 64'd1);
    exp_q.push_back('{rs: {32'h0, 32'hA5}, rd: 5'd0, we: 1'b0, pl: 64'hBEEF_0003_0000_0001});
    tick();
    in_valid = 1'b0;
    set_wb(2'b00, 0, 0, 0, 0);

    // Backpressure: held output stays stable, new instruction waits.
    out_ready = 1'b0;
    in_valid = 1'b1; in_rs = {5'd7, 5'd5}; in_rd = 5'd0; in_rd_we = 1'b0;
    in_payload = 64'hBEEF_0000_0000_00B2;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_in_ready", {63'd0, in_ready}, 64'd0);
      check("bp_hold_data", out_rs_data, {32'h0, 32'hA5});
      check("bp_hold_valid", {63'd0, out_valid}, 64'd1);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("bp_release", {63'd0, in_ready}, 64'd1);
    exp_q.push_back('{rs: {32'h1234, 32'hDEADBEEF}, rd: 5'd0, we: 1'b0, pl: 64'hBEEF_0000_0000_00B2});
    tick();
    in_valid = 1'b0;

    // Dual write-back to x9: port 1 wins; write to x0 is dropped.
    set_wb(2'b11, 9, 32'h11, 9, 32'h22);
    tick();
    set_wb(2'b01, 0, 32'hFFFFFFFF, 0, 0);
    tick();
    set_wb(2'b00, 0, 0, 0, 0);
    issue(9, 0, 0, 0, 32'h22, 32'h0, 1'b1);
    set_wb(2'b11, 10, 32'h33, 10, 32'h44);
    issue(10, 0, 0, 0, 32'h44, 32'h0, 1'b1);
    set_wb(2'b01, 0, 32'hFFFFFFFF, 0, 0);
    issue(0, 10, 0, 0, 32'h0, 32'h44, 1'b1);
    set_wb(2'b00, 0, 0, 0, 0);

    // WAW hazard on x8, released by same-cycle write-back.
    issue(0, 0, 8, 1'b1, 32'h0, 32'h0, 1'b1);
    issue(0, 0, 8, 1'b1, 32'h0, 32'h0, 1'b0);
    set_wb(2'b10, 0, 0, 8, 32'h77);
    issue(8, 0, 0, 0, 32'h77, 32'h0, 1'b1);
    set_wb(2'b00, 0, 0, 0, 0);
    tick();

    // Flush with busy[4]=1 and a held output.
    out_ready = 1'b0;
    issue(0, 0, 4, 1'b1, 32'h0, 32'h0, 1'b1);
    flush = 1'b1;
    #1;
    check("flush_in_ready", {63'd0, in_ready}, 64'd0);
    tick();
    flush = 1'b0;
    exp_q.delete(exp_q.size() - 1);
    check("flush_out_valid", {63'd0, out_valid}, 64'd0);
    out_ready = 1'b1;
    issue(4, 0, 0, 0, 32'h0, 32'h0, 1'b1);
    tick();

    // Asynchronous reset in the middle of a stall.
    issue(0, 0, 6, 1'b1, 32'h0, 32'h0, 1'b1);
    out_ready = 1'b0;
    in_valid = 1'b1; in_rs = {5'd0, 5'd6}; in_rd = 5'd0; in_rd_we = 1'b0;
    #1;
    check("rst_mid_stall", {63'd0, in_ready}, 64'd0);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", {63'd0, out_valid}, 64'd0);
    check("arst_out_rs_data", out_rs_data, 64'd0);
    check("arst_out_rd", {59'd0, out_rd}, 64'd0);
    check("arst_out_rd_we", {63'd0, out_rd_we}, 64'd0);
    check("arst_out_payload", out_payload, 64'd0);
    exp_q.delete();
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    issue(5, 9, 0, 0, 32'h0, 32'h0, 1'b1);
    tick();
    tick();

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
